// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared constants, state type and frame builder for spi_mem_ctrl
package spi_mem_pkg;

   localparam logic [7:0] SPI_CMD_READ   = 8'h03;
   localparam logic [7:0] SPI_CMD_WRITE  = 8'h02;
   localparam int         SPI_FRAME_BITS = 48;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE,
      FAULT
   } spi_state_e;

   // Data field is little-endian: byte at addr (wdata[7:0]) goes out first.
   function automatic logic [47:0] build_frame(input logic        wr,
                                               input logic [23:0] addr,
                                               input logic [15:0] wdata);
      logic [7:0]  opcode;
      logic [15:0] data_field;
      opcode     = wr ? SPI_CMD_WRITE : SPI_CMD_READ;
      data_field = wr ? {wdata[7:0], wdata[15:8]} : 16'h0000;
      return {opcode, addr, data_field};
   endfunction

endpackage

// File: rtl/spi_mem_phase_timer.sv
// rtl/spi_mem_phase_timer.sv - spi_clk half-period divider with rise/fall strobes
module spi_mem_phase_timer #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic rise,
   output logic fall,
   output logic sclk
);

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

   logic [3:0] cnt;
   logic       level;
   logic       wrap;

   // Strobes mark the edge on which the level toggles.
   assign wrap = run && (cnt == DIV_LAST);
   assign rise = wrap && !level;
   assign fall = wrap && level;
   assign sclk = level;

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         cnt   <= 4'd0;
         level <= 1'b0;
      end else if (cnt == DIV_LAST) begin
         cnt   <= 4'd0;
         level <= ~level;
      end else begin
         cnt   <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/spi_mem_ctrl.sv
// rtl/spi_mem_ctrl.sv - 16-bit word SPI serial-SRAM master; SPI_MEM_FAULT_EN enables address faults
module spi_mem_ctrl #(
   parameter int          CLK_DIV    = 1,
   parameter logic [23:0] ADDR_LIMIT = 24'h020000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [23:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_fault,
   output logic        busy,
   output logic        spi_select,
   output logic        spi_clk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   import spi_mem_pkg::*;

   spi_state_e  state, state_nxt;
   logic [47:0] sr;
   logic [47:0] sr_next;
   logic [5:0]  bit_cnt;
   logic        wr_q;
   logic [15:0] rdata_q;
   logic        accept;
   logic        req_bad;
   logic [23:0] addr_eff;
   logic        rise, fall;

`ifdef SPI_MEM_FAULT_EN
   assign addr_eff   = req_addr;
   assign req_bad    = (req_addr >= ADDR_LIMIT) || req_addr[0];
   assign resp_fault = (state == FAULT);
`else
   logic unused_cfg;
   assign addr_eff   = {req_addr[23:1], 1'b0};
   assign req_bad    = 1'b0;
   assign resp_fault = 1'b0;
   assign unused_cfg = &{1'b0, req_addr[0], ADDR_LIMIT};
`endif

   assign req_ready  = (state == IDLE) && !rst;
   assign accept     = req_valid && req_ready;
   assign busy       = (state != IDLE);
   assign resp_valid = (state == DONE) || (state == FAULT);
   assign resp_rdata = rdata_q;
   assign spi_select = (state == SHIFT);
   assign spi_mosi   = (state == SHIFT) && sr[47];
   assign sr_next    = {sr[46:0], spi_miso};

   spi_mem_phase_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .run  (state == SHIFT),
      .rise (rise),
      .fall (fall),
      .sclk (spi_clk)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = req_bad ? FAULT : SHIFT;
         SHIFT:   if (fall && (bit_cnt == 6'd0)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         FAULT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One register serves both directions: MOSI leaves from bit 47 while MISO
   // enters at bit 0, so the last 16 samples land in sr_next[15:0].
   always_ff @(posedge clk) begin
      if (rst) begin
         sr      <= 48'h0;
         bit_cnt <= 6'd0;
         wr_q    <= 1'b0;
         rdata_q <= 16'h0000;
      end else if (accept && !req_bad) begin
         sr      <= build_frame(req_write, addr_eff, req_wdata);
         bit_cnt <= 6'(SPI_FRAME_BITS - 1);
         wr_q    <= req_write;
      end else if ((state == SHIFT) && fall) begin
         sr <= sr_next;
         if (bit_cnt != 6'd0) begin
            bit_cnt <= bit_cnt - 6'd1;
         end else if (!wr_q) begin
            rdata_q <= {sr_next[7:0], sr_next[15:8]};
         end
      end
   end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb/tb_spi_mem_ctrl.sv - scoreboard bench for spi_mem_ctrl at CLK_DIV 1 and 3 (SPI_MEM_FAULT_EN aware)
module tb_spi_mem_ctrl;

   typedef struct {
      int          inst;
      logic [15:0] rdata;
      logic        fault;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv [2];
   logic        rw [2];
   logic [23:0] ra [2];
   logic [15:0] rwd [2];
   logic        rdy [2];
   logic        resp_v [2];
   logic [15:0] rdata [2];
   logic        fault [2];
   logic        busy [2];
   logic        sel [2];
   logic        sclk [2];
   logic        mosi [2];
   logic        miso [2];

   exp_t        sb [$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          acc_edge = 0;
   int          last_resp = 0;
   logic [7:0]  mem [0:1023];

   int          rises [2], run_len [2], sel_len [2], low_len [2], frames [2], sel_rises [2];
   logic        psel [2], psc [2], abort [2];
   logic [47:0] frame [2], last_frame [2];
   int          md, mslot;
   logic [23:0] ma;
   logic [15:0] mst;

   always #5 clk = ~clk;

   spi_mem_ctrl #(.CLK_DIV(1)) dut0 (
      .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]),
      .req_addr(ra[0]), .req_wdata(rwd[0]), .resp_valid(resp_v[0]), .resp_rdata(rdata[0]),
      .resp_fault(fault[0]), .busy(busy[0]), .spi_select(sel[0]), .spi_clk(sclk[0]),
      .spi_mosi(mosi[0]), .spi_miso(miso[0])
   );

   spi_mem_ctrl #(.CLK_DIV(3)) dut1 (
      .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]),
      .req_addr(ra[1]), .req_wdata(rwd[1]), .resp_valid(resp_v[1]), .resp_rdata(rdata[1]),
      .resp_fault(fault[1]), .busy(busy[1]), .spi_select(sel[1]), .spi_clk(sclk[1]),
      .spi_mosi(mosi[1]), .spi_miso(miso[1])
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor: pops the scoreboard on every resp_valid
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rv[i] === 1'b1 && rdy[i] === 1'b1) acc_edge = cyc + 1;
         if (resp_v[i] === 1'b1) begin
            if (sb.size() == 0 || sb[0].inst != i) begin
               total++;
               bad++;
               $display("FAIL unexpected_resp inst=%0d: got resp_valid=1 expected none", i);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("resp_rdata", rdata[i], e.rdata);
               chk("resp_fault", fault[i], e.fault);
               chk("latency", cyc - acc_edge + 1, e.lat);
            end
            last_resp = cyc;
         end
      end
   end

   // Serial SRAM model and SPI timing checker, one per DUT
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         md = (i == 0) ? 1 : 3;
         if (rst === 1'b1 && sel[i] === 1'b1) abort[i] = 1'b1;
         if (sel[i] === 1'b1 && !psel[i]) begin
            if (frames[i] > 0) chk("sel_gap", low_len[i] >= 2, 1);
            rises[i] = 0; frame[i] = 48'h0; run_len[i] = 0; sel_len[i] = 0;
            abort[i] = 1'b0; sel_rises[i]++;
         end
         if (sel[i] === 1'b1 || psel[i]) begin
            if (sclk[i] !== psc[i] && !abort[i]) begin
               chk("half_period", run_len[i], md);
               run_len[i] = 1;
            end else begin
               run_len[i]++;
            end
         end
         if (sel[i] === 1'b1 && sclk[i] === 1'b1 && !psc[i] && rises[i] < 48) begin
            frame[i][47 - rises[i]] = mosi[i];
            rises[i]++;
         end
         if (sel[i] === 1'b1) sel_len[i]++;
         miso[i] = 1'($urandom_range(0, 1));
         if (sel[i] === 1'b1 && sclk[i] === 1'b1 && rises[i] >= 33 && frame[i][47:40] == 8'h03) begin
            ma    = frame[i][39:16];
            mst   = {mem[ma[9:0]], mem[ma[9:0] + 10'd1]};
            mslot = rises[i] - 1;
            miso[i] = mst[15 - (mslot - 32)];
         end
         if (sel[i] !== 1'b1 && psel[i]) begin
            if (!abort[i]) begin
               chk("sel_len", sel_len[i], 96 * md);
               if (frame[i][47:40] == 8'h02) begin
                  ma = frame[i][39:16];
                  mem[ma[9:0]]         = frame[i][15:8];
                  mem[ma[9:0] + 10'd1] = frame[i][7:0];
               end
               frames[i]++;
               last_frame[i] = frame[i];
            end
            low_len[i] = 0;
         end
         if (sel[i] !== 1'b1) low_len[i]++;
         psel[i] = (sel[i] === 1'b1);
         psc[i]  = (sclk[i] === 1'b1);
      end
   end

   task automatic send(input int i, input logic wr, input logic [23:0] a, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic f, input int lat);
      exp_t e;
      int   n;
      e.inst = i; e.rdata = exp_rd; e.fault = f; e.lat = lat;
      sb.push_back(e);
      rv[i] = 1'b1; rw[i] = wr; ra[i] = a; rwd[i] = wd;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rdy[i] !== 1'b1 && n < 500);
      @(posedge clk); #1;
      rv[i] = 1'b0;
      if (n >= 500) begin
         total++; bad++;
         $display("FAIL accept_timeout inst=%0d: got no accept expected accept", i);
      end
      n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL resp_timeout inst=%0d: got no resp_valid expected resp_valid", i);
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int   n;
      int   a2;
      int   s0;
      exp_t e;
      for (int k = 0; k < 1024; k++) mem[k] = 8'h00;
      for (int i = 0; i < 2; i++) begin
         rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = 24'h0; rwd[i] = 16'h0; miso[i] = 1'b0;
         psel[i] = 1'b0; psc[i] = 1'b0; abort[i] = 1'b0; frames[i] = 0; sel_rises[i] = 0;
         rises[i] = 0; run_len[i] = 0; sel_len[i] = 0; low_len[i] = 0;
         frame[i] = 48'h0; last_frame[i] = 48'h0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_init", rdy[0], 1'b1);
      @(posedge clk); #1;

      // Reset in the middle of a write frame
      rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 24'h000020; rwd[0] = 16'h1234;
      n = 0;
      do begin @(negedge clk); n++; end while (rdy[0] !== 1'b1 && n < 50);
      @(posedge clk); #1 rv[0] = 1'b0;
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("ready_in_reset", rdy[0], 1'b0);
      @(negedge clk);
      chk("rst_select", sel[0], 1'b0);
      chk("rst_spi_clk", sclk[0], 1'b0);
      chk("rst_mosi", mosi[0], 1'b0);
      chk("rst_busy", busy[0], 1'b0);
      chk("rst_resp_valid", resp_v[0], 1'b0);
      chk("rst_resp_fault", fault[0], 1'b0);
      chk("rst_resp_rdata", rdata[0], 16'h0000);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_release", rdy[0], 1'b1);
      chk("ready_after_release_d3", rdy[1], 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_write", {mem[32], mem[33]}, 16'h0000);

      send(0, 1'b1, 24'h000010, 16'hBEEF, 16'h0000, 1'b0, 97);
      chk("write_frame", last_frame[0], 48'h02000010EFBE);
      chk("ram_0x10", mem[16], 8'hEF);
      chk("ram_0x11", mem[17], 8'hBE);

      send(0, 1'b0, 24'h000010, 16'h0000, 16'hBEEF, 1'b0, 97);
      chk("read_frame_hdr", last_frame[0][47:16], 32'h03000010);

      send(0, 1'b1, 24'h000014, 16'h1234, 16'hBEEF, 1'b0, 97);
      chk("ram_0x14", mem[20], 8'h34);
      chk("ram_0x15", mem[21], 8'h12);

      send(1, 1'b0, 24'h000014, 16'h0000, 16'h1234, 1'b0, 289);
      chk("read_d3_hdr", last_frame[1][47:16], 32'h03000014);

      // Back-to-back reads with req_valid held high
      e.inst = 0; e.fault = 1'b0; e.lat = 97;
      e.rdata = 16'hBEEF; sb.push_back(e);
      e.rdata = 16'h1234; sb.push_back(e);
      rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 24'h000010;
      n = 0;
      do begin @(negedge clk); n++; end while (rdy[0] !== 1'b1 && n < 50);
      @(posedge clk); #1 ra[0] = 24'h000014;
      n = 0;
      do begin @(negedge clk); n++; end while (rdy[0] !== 1'b1 && n < 300);
      a2 = cyc + 1;
      @(posedge clk); #1 rv[0] = 1'b0;
      chk("b2b_gap", a2 - last_resp, 2);
      n = 0;
      while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
      chk("b2b_drained", sb.size(), 0);
      sb.delete();
      @(posedge clk); #1;

`ifdef SPI_MEM_FAULT_EN
      s0 = sel_rises[0];
      send(0, 1'b0, 24'h020000, 16'h0000, 16'h1234, 1'b1, 1);
      send(0, 1'b0, 24'h000011, 16'h0000, 16'h1234, 1'b1, 1);
      chk("fault_no_select", sel_rises[0], s0);
`else
      s0 = sel_rises[0];
      send(0, 1'b0, 24'h000011, 16'h0000, 16'hBEEF, 1'b0, 97);
      chk("aligned_hdr", last_frame[0][47:16], 32'h03000010);
      chk("aligned_one_frame", sel_rises[0], s0 + 1);
`endif

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
